// File: rtl/radar_pkg.sv
// radar_pkg: shared states, slot indices and constants for the radar sweep sequencer
package radar_pkg;
  typedef enum logic [2:0] {IDLE, MOVE, SETTLE, MEASURE, STORE, DONE} state_e;
  localparam logic [1:0] SLOT_L = 2'd0;
  localparam logic [1:0] SLOT_C = 2'd1;
  localparam logic [1:0] SLOT_R = 2'd2;
  localparam logic [8:0] DIST_MAX = 9'h1FF;
  localparam logic [1:0] CLOSEST_NONE = 2'd3;
  // Nearest answering slot as {index, distance}; ties resolve toward the lower index
  function automatic logic [10:0] pick_closest(input logic [2:0][8:0] d, input logic [2:0] t);
    logic [1:0] idx;
    logic [8:0] best;
    idx = CLOSEST_NONE;
    best = DIST_MAX;
    for (int i = 0; i < 3; i++)
      if (!t[i] && (idx == CLOSEST_NONE || d[i] < best)) begin
        idx = 2'(i);
        best = d[i];
      end
    return {idx, best};
  endfunction
endpackage

// File: rtl/radar_servo_pwm.sv
// radar_servo_pwm: servo frame generator whose pulse width only changes on a frame boundary
module radar_servo_pwm #(
  parameter int PWM_PERIOD = 2_000_000,
  parameter int PULSE_C    = 150_000,
  parameter int WW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_we_i,
  input  logic [WW-1:0] req_width_i,
  output logic          servo_pwm_o,
  output logic          synced_o
);
  localparam int CW = $clog2(PWM_PERIOD);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] act_q, act_d, req_q, req_d;
  logic wrap;
  assign wrap = cnt_q == CW'(PWM_PERIOD - 1);
  // Requested width waits in req_q and is adopted by the active frame only at the wrap
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    req_d = req_we_i ? req_width_i : req_q;
    act_d = wrap ? req_q : act_q;
  end
  // Frame counter and width registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      act_q <= WW'(PULSE_C);
      req_q <= WW'(PULSE_C);
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      req_q <= req_d;
    end
  assign servo_pwm_o = ~rst & (WW'(cnt_q) < act_q);
  assign synced_o = cnt_q == '0 && act_q == req_q;
endmodule

// File: rtl/radar_barrido.sv
// radar_barrido: three-angle servo sweep that requests and collects ultrasonic ranges; RADAR_CLOSEST_EN adds nearest-slot outputs
module radar_barrido
  import radar_pkg::*;
#(
  parameter int PWM_PERIOD  = 2_000_000,
  parameter int PULSE_L     = 200_000,
  parameter int PULSE_C     = 150_000,
  parameter int PULSE_R     = 100_000,
  parameter int SETTLE_CYC  = 30_000_000,
  parameter int TIMEOUT_CYC = 6_000_000,
  parameter int DIST_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              servo_pwm,
  output logic              us_init,
  input  logic              us_done,
  input  logic [DIST_W-1:0] us_dist,
  output logic [DIST_W-1:0] dist_l,
  output logic [DIST_W-1:0] dist_c,
  output logic [DIST_W-1:0] dist_r,
  output logic [2:0]        tout,
`ifdef RADAR_CLOSEST_EN
  output logic [1:0]        closest,
  output logic [DIST_W-1:0] closest_dist,
`endif
  output logic              valid
);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int WW = $clog2(PWM_PERIOD + 1);
  state_e state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0][DIST_W-1:0] dist_q, dist_d;
  logic [2:0] tout_q, tout_d;
  logic req_we, synced, got, expired;
  logic [WW-1:0] req_width;
  radar_servo_pwm #(.PWM_PERIOD(PWM_PERIOD), .PULSE_C(PULSE_C), .WW(WW)) u_pwm (
    .clk(clk),
    .rst(rst),
    .req_we_i(req_we),
    .req_width_i(req_width),
    .servo_pwm_o(servo_pwm),
    .synced_o(synced)
  );
  // The first MEASURE cycle may still see the previous slot's done level, so it is skipped
  assign got = state_q == MEASURE && tmo_q != '0 && us_done;
  assign expired = tmo_q == TW'(TIMEOUT_CYC - 1);
  // Next-state, counters, result capture and servo width requests
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    settle_d = settle_q;
    tmo_d = tmo_q;
    dist_d = dist_q;
    tout_d = tout_q;
    req_we = 1'b0;
    req_width = WW'(PULSE_C);
    case (state_q)
      IDLE: if (start) begin
        slot_d = SLOT_L;
        req_we = 1'b1;
        req_width = WW'(PULSE_L);
        state_d = MOVE;
      end
      MOVE: if (synced) begin
        settle_d = '0;
        state_d = SETTLE;
      end
      SETTLE: if (settle_q == SW'(SETTLE_CYC - 1)) begin
        tmo_d = '0;
        state_d = MEASURE;
      end else settle_d = settle_q + 1'b1;
      MEASURE: if (got || expired) begin
        dist_d[slot_q] = got ? us_dist : DIST_W'(DIST_MAX);
        tout_d[slot_q] = !got;
        state_d = STORE;
      end else tmo_d = tmo_q + 1'b1;
      STORE: if (slot_q == SLOT_R) state_d = DONE;
      else begin
        slot_d = slot_q == SLOT_L ? SLOT_C : SLOT_R;
        req_we = 1'b1;
        req_width = slot_q == SLOT_L ? WW'(PULSE_C) : WW'(PULSE_R);
        state_d = MOVE;
      end
      DONE: begin
        req_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Sequencer state, counters and published results
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      slot_q <= SLOT_L;
      settle_q <= '0;
      tmo_q <= '0;
      dist_q <= '0;
      tout_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      settle_q <= settle_d;
      tmo_q <= tmo_d;
      dist_q <= dist_d;
      tout_q <= tout_d;
    end
  assign busy = state_q != IDLE;
  assign us_init = state_q == MEASURE;
  assign valid = state_q == DONE;
  assign dist_l = dist_q[SLOT_L];
  assign dist_c = dist_q[SLOT_C];
  assign dist_r = dist_q[SLOT_R];
  assign tout = tout_q;
`ifdef RADAR_CLOSEST_EN
  logic [1:0] closest_q;
  logic [DIST_W-1:0] cdist_q;
  logic [10:0] pick;
  assign pick = pick_closest(dist_q, tout_q);
  // Latch the nearest answering slot as the sweep enters DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      closest_q <= CLOSEST_NONE;
      cdist_q <= DIST_W'(DIST_MAX);
    end else if (state_q == STORE && slot_q == SLOT_R) begin
      closest_q <= pick[10:9];
      cdist_q <= DIST_W'(pick[8:0]);
    end
  assign closest = closest_q;
  assign closest_dist = cdist_q;
`endif
endmodule

// File: tb/tb_radar_barrido.sv
// tb_radar_barrido: directed and randomized sweeps against a ranging-stage stand-in and a result model
module tb_radar_barrido;
  localparam int PWM_PERIOD = 100, PULSE_L = 20, PULSE_C = 15, PULSE_R = 10;
  localparam int SETTLE_CYC = 300, TIMEOUT_CYC = 500, DIST_W = 9, NEVER = 100000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, us_done = 1'b0;
  logic [8:0] us_dist = '0;
  logic busy, servo_pwm, us_init, valid;
  logic [8:0] dist_l, dist_c, dist_r;
  logic [2:0] tout;
`ifdef RADAR_CLOSEST_EN
  logic [1:0] closest;
  logic [8:0] closest_dist;
`endif
  int errors = 0, checks = 0;
  int rep_dist[3], rep_delay[3], init_len[3];
  int meas_n = 0, icnt = 0;
  int vcount = 0, bad_runs = 0, bad_period = 0, run = 0, since_rise = -1;
  logic prev_pwm = 1'b0;

  always #5 clk = ~clk;

  radar_barrido #(
    .PWM_PERIOD(PWM_PERIOD), .PULSE_L(PULSE_L), .PULSE_C(PULSE_C), .PULSE_R(PULSE_R),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .DIST_W(DIST_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .servo_pwm(servo_pwm),
    .us_init(us_init), .us_done(us_done), .us_dist(us_dist),
    .dist_l(dist_l), .dist_c(dist_c), .dist_r(dist_r), .tout(tout),
`ifdef RADAR_CLOSEST_EN
    .closest(closest), .closest_dist(closest_dist),
`endif
    .valid(valid)
  );

  // Ranging-stage stand-in: raises done rep_delay cycles into a request, drops it when the request ends
  always begin
    @(posedge clk);
    #1;
    if (!busy) meas_n = 0;
    if (us_init) begin
      icnt++;
      if (icnt > rep_delay[meas_n]) begin
        us_done = 1'b1;
        us_dist = 9'(rep_dist[meas_n]);
      end
    end else begin
      if (icnt > 0) begin
        init_len[meas_n] = icnt;
        meas_n++;
      end
      icnt = 0;
      us_done = 1'b0;
    end
  end

  // Waveform monitor: every high run must be a legal width and every frame exactly one period
  always @(negedge clk) begin
    if (valid) vcount++;
    if (rst) begin
      run = 0;
      since_rise = -1;
      prev_pwm = 1'b0;
    end else begin
      if (since_rise >= 0) since_rise++;
      if (servo_pwm && !prev_pwm) begin
        if (since_rise >= 0 && since_rise != PWM_PERIOD) bad_period++;
        since_rise = 0;
      end
      if (servo_pwm) run++;
      else if (prev_pwm) begin
        if (!(run inside {PULSE_L, PULSE_C, PULSE_R})) bad_runs++;
        run = 0;
      end
      prev_pwm = servo_pwm;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic set_rep(input int d0, input int w0, input int d1, input int w1, input int d2, input int w2);
    rep_dist[0] = d0;
    rep_delay[0] = w0;
    rep_dist[1] = d1;
    rep_delay[1] = w1;
    rep_dist[2] = d2;
    rep_delay[2] = w2;
  endtask

  task automatic run_sweep(input string tag, input bit extra_start);
    int n, v0, best, bidx;
    bit ok[3];
    logic [8:0] exp_d[3];
    logic [2:0] exp_t;
    v0 = vcount;
    pulse_start();
    if (extra_start) begin
      n = 0;
      while (meas_n != 1 && n < 4000) begin
        @(posedge clk);
        n++;
      end
      repeat (150) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    n = 0;
    while (!valid && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, valid, 1);
    best = 511;
    bidx = 3;
    for (int i = 0; i < 3; i++) begin
      ok[i] = rep_delay[i] <= TIMEOUT_CYC - 1;
      exp_d[i] = ok[i] ? 9'(rep_dist[i]) : 9'h1FF;
      exp_t[i] = !ok[i];
      if (ok[i] && rep_dist[i] < best) best = rep_dist[i];
    end
    for (int i = 2; i >= 0; i--) if (ok[i] && rep_dist[i] == best) bidx = i;
    chk({tag, "_dist_l"}, dist_l, exp_d[0]);
    chk({tag, "_dist_c"}, dist_c, exp_d[1]);
    chk({tag, "_dist_r"}, dist_r, exp_d[2]);
    chk({tag, "_tout"}, tout, exp_t);
    chk({tag, "_busy_in_done"}, busy, 1);
`ifdef RADAR_CLOSEST_EN
    chk({tag, "_closest"}, closest, bidx);
    chk({tag, "_closest_dist"}, closest_dist, best);
`endif
    repeat (20) @(negedge clk);
    chk({tag, "_valid_pulses"}, vcount - v0, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_init_after"}, us_init, 0);
    for (int i = 0; i < 3; i++) chk({tag, "_init_len"}, init_len[i], ok[i] ? rep_delay[i] + 1 : TIMEOUT_CYC);
  endtask

  initial begin
    int hi, q, n, pick;
    set_rep(0, NEVER, 0, NEVER, 0, NEVER);
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pwm", servo_pwm, 0);
    chk("rst_init", us_init, 0);
    chk("rst_valid", valid, 0);
    chk("rst_tout", tout, 0);
    chk("rst_dists", {dist_l, dist_c, dist_r}, 0);
`ifdef RADAR_CLOSEST_EN
    chk("rst_closest", closest, 3);
    chk("rst_closest_dist", closest_dist, 511);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    hi = 0;
    q = 0;
    repeat (1000) begin
      @(negedge clk);
      if (servo_pwm) hi++;
      if (busy || us_init || valid) q++;
    end
    chk("idle_pwm_high", hi, 150);
    chk("idle_quiet", q, 0);
    set_rep(120, 50, 45, 50, 300, 50);
    run_sweep("basic", 1'b0);
    set_rep(200, 30, 77, NEVER, 10, 80);
    run_sweep("c_timeout", 1'b0);
    set_rep(33, 20, 34, 40, 35, 60);
    run_sweep("start_in_settle", 1'b1);
    set_rep(80, 499, 80, 499, 90, 499);
    run_sweep("coincide", 1'b0);
    set_rep(400, 500, 401, 500, 402, 500);
    run_sweep("all_timeout", 1'b0);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 3; i++) begin
        rep_dist[i] = $urandom_range(0, 511);
        pick = $urandom_range(0, 3);
        rep_delay[i] = pick == 0 ? $urandom_range(1, 300) : pick == 1 ? 499 : pick == 2 ? 500 : NEVER;
      end
      run_sweep("random", 1'b0);
    end
    set_rep(1, NEVER, 2, NEVER, 3, NEVER);
    pulse_start();
    n = 0;
    while (!(meas_n == 2 && us_init) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reached_r", meas_n == 2 && us_init, 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_init", us_init, 0);
    chk("mid_rst_pwm", servo_pwm, 0);
    chk("mid_rst_tout", tout, 0);
    chk("mid_rst_dists", {dist_l, dist_c, dist_r}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    set_rep(250, 10, 260, 20, 240, 30);
    run_sweep("after_rst", 1'b0);
    chk("pwm_run_widths", bad_runs, 0);
    chk("pwm_frame_period", bad_period, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
